// File: rtl/imm_gen_pipe_pkg.sv
// imm_gen_pipe_pkg: RV32I opcodes and immediate format codes shared by the immediate generator
package imm_gen_pipe_pkg;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [2:0] FMT_NONE  = 3'd0;
  localparam logic [2:0] FMT_I     = 3'd1;
  localparam logic [2:0] FMT_S     = 3'd2;
  localparam logic [2:0] FMT_B     = 3'd3;
  localparam logic [2:0] FMT_U     = 3'd4;
  localparam logic [2:0] FMT_J     = 3'd5;
endpackage

// File: rtl/imm_gen_pipe_decode.sv
// imm_decode_comb: combinational RV32I immediate extraction and sign extension to XLEN
module imm_decode_comb
  import imm_gen_pipe_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      fmt,
  output logic            illegal
);
  logic [6:0]  op;
  logic [31:0] imm32;
  assign op = instr[6:0];
  // classify the opcode, then pick the matching bit scramble; unknown opcodes yield zero
  always_comb begin
    fmt = (op == OP_LOAD || op == OP_IMM || op == OP_JALR || op == OP_SYSTEM) ? FMT_I :
          (op == OP_STORE) ? FMT_S :
          (op == OP_BRANCH) ? FMT_B :
          (op == OP_LUI || op == OP_AUIPC) ? FMT_U :
          (op == OP_JAL) ? FMT_J : FMT_NONE;
    illegal = (fmt == FMT_NONE);
    imm32 = (fmt == FMT_I) ? {{20{instr[31]}}, instr[31:20]} :
            (fmt == FMT_S) ? {{20{instr[31]}}, instr[31:25], instr[11:7]} :
            (fmt == FMT_B) ? {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0} :
            (fmt == FMT_U) ? {instr[31:12], 12'b0} :
            (fmt == FMT_J) ? {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0} :
            32'd0;
  end
  assign imm = XLEN'($signed(imm32));
endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: one-cycle pipelined immediate generator with optional 2-entry skid buffer and flush
module imm_gen_pipe
  import imm_gen_pipe_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int SKID  = 1,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);
  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [2:0]       fmt;
    logic             ill;
    logic [TAG_W-1:0] tag;
  } ent_t;
  ent_t dec, main_q, main_d, skid_q, skid_d;
  logic main_v_q, main_v_d, skid_v_q, skid_v_d;
  logic accept, pop, ld_skid, ld_main_in, ld_main_sk;
  imm_decode_comb #(.XLEN(XLEN)) u_dec (
    .instr   (in_instr),
    .imm     (dec.imm),
    .fmt     (dec.fmt),
    .illegal (dec.ill)
  );
  assign dec.tag     = in_tag;
  assign in_ready    = (SKID != 0) ? !skid_v_q : (!main_v_q || out_ready);
  assign accept      = in_valid && in_ready;
  assign pop         = main_v_q && out_ready;
  assign out_valid   = main_v_q;
  assign out_imm     = main_q.imm;
  assign out_fmt     = main_q.fmt;
  assign out_illegal = main_q.ill;
  assign out_tag     = main_q.tag;
  // steer new entries to main or skid; the skid drains into main before any newer input
  always_comb begin
    ld_skid    = accept && main_v_q && !out_ready;
    ld_main_in = accept && !ld_skid;
    ld_main_sk = pop && skid_v_q;
    main_d     = ld_main_in ? dec : ld_main_sk ? skid_q : main_q;
    skid_d     = ld_skid ? dec : skid_q;
    main_v_d   = flush ? 1'b0 : (ld_main_in || ld_main_sk) ? 1'b1 : pop ? 1'b0 : main_v_q;
    skid_v_d   = flush ? 1'b0 : ld_skid ? 1'b1 : ld_main_sk ? 1'b0 : skid_v_q;
  end
  // state registers; reset also clears the stored payloads so outputs read zero
  always_ff @(posedge clk) begin
    if (rst) begin
      main_q   <= '0;
      skid_q   <= '0;
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
    end else begin
      main_q   <= main_d;
      skid_q   <= skid_d;
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
    end
  end
endmodule
